// File: rtl/sign_extend_unit.sv
// Registered immediate extension: widens an IN_WIDTH immediate to OUT_WIDTH
// using sign, zero, upper or byte-sign extension, one cycle of latency.
module sign_extend_unit #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic [1:0]           mode,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid
);

  // IN_WIDTH >= 8 keeps in[7:0] addressable; OUT_WIDTH >= 2*IN_WIDTH keeps
  // the upper mode lossless.
  localparam int FILL_W  = OUT_WIDTH - IN_WIDTH;
  localparam int FILL8_W = OUT_WIDTH - 8;

  typedef enum logic [1:0] {
    MODE_SEXT  = 2'b00,
    MODE_ZEXT  = 2'b01,
    MODE_UPPER = 2'b10,
    MODE_SEXT8 = 2'b11
  } mode_e;

  logic [OUT_WIDTH-1:0] ext;
  logic [OUT_WIDTH-1:0] out_d, out_q;
  logic                 out_valid_d, out_valid_q;

  always_comb begin
    ext = {{FILL_W{in[IN_WIDTH-1]}}, in};
    unique case (mode_e'(mode))
      MODE_SEXT:  ext = {{FILL_W{in[IN_WIDTH-1]}}, in};
      MODE_ZEXT:  ext = {{FILL_W{1'b0}}, in};
      MODE_UPPER: ext = {in, {FILL_W{1'b0}}};
      MODE_SEXT8: ext = {{FILL8_W{in[7]}}, in[7:0]};
      default:    ext = {{FILL_W{in[IN_WIDTH-1]}}, in};
    endcase
  end

  // Idle cycles hold the last result but drop the qualifier.
  always_comb begin
    out_d       = out_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      out_d = ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Self-checking bench for sign_extend_unit: directed boundary cases plus
// random traffic against an arithmetic reference model.
module tb_sign_extend_unit;

  logic        clk;
  logic        rst;
  logic [15:0] in_s;
  logic [1:0]  mode_s;
  logic        in_valid_s;
  logic [31:0] out_s;
  logic        out_valid_s;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_out;

  sign_extend_unit #(.IN_WIDTH(16), .OUT_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_s),
    .mode      (mode_s),
    .in_valid  (in_valid_s),
    .out       (out_s),
    .out_valid (out_valid_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference built from plain integer arithmetic on the value of the field.
  function automatic logic [31:0] ref_ext(input logic [15:0] v, input logic [1:0] m);
    longint val;
    longint b;
    val = longint'(v);
    b   = val % 256;
    case (m)
      2'd0:    return 32'((val >= 32768) ? val + 64'h1_0000_0000 - 65536 : val);
      2'd1:    return 32'(val);
      2'd2:    return 32'(val * 65536);
      default: return 32'((b >= 128) ? b + 64'h1_0000_0000 - 256 : b);
    endcase
  endfunction

  task automatic drive_and_check(input logic [15:0] v, input logic [1:0] m,
                                 input logic vld, input string tag);
    in_s       = v;
    mode_s     = m;
    in_valid_s = vld;
    @(posedge clk);
    #1;
    if (vld) exp_out = ref_ext(v, m);
    check({tag, "_out"}, out_s, exp_out);
    check({tag, "_vld"}, {31'b0, out_valid_s}, {31'b0, vld});
  endtask

  initial begin
    rst        = 1'b1;
    in_s       = 16'hFFFF;
    mode_s     = 2'b00;
    in_valid_s = 1'b1;
    exp_out    = '0;
    #3;
    check("rst_out", out_s, 32'h0);
    check("rst_vld", {31'b0, out_valid_s}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_out", out_s, 32'h0);
    check("rst_hold_vld", {31'b0, out_valid_s}, 32'h0);
    rst = 1'b0;
    #2;
    check("rel_out", out_s, 32'h0);
    check("rel_vld", {31'b0, out_valid_s}, 32'h0);
    drive_and_check(16'hFFFF, 2'b00, 1'b1, "first_cap");

    drive_and_check(16'h0001, 2'b00, 1'b1, "sext_pos");
    drive_and_check(16'hFFFF, 2'b00, 1'b1, "sext_neg");
    drive_and_check(16'h7FFF, 2'b00, 1'b1, "sext_max");
    check("sext_max_const", out_s, 32'h00007FFF);
    drive_and_check(16'h8000, 2'b00, 1'b1, "sext_min");
    check("sext_min_const", out_s, 32'hFFFF8000);
    drive_and_check(16'hFF80, 2'b01, 1'b1, "zext");
    check("zext_const", out_s, 32'h0000FF80);
    drive_and_check(16'hFF80, 2'b10, 1'b1, "upper");
    check("upper_const", out_s, 32'hFF800000);
    drive_and_check(16'hFF80, 2'b11, 1'b1, "sext8_neg");
    check("sext8_neg_const", out_s, 32'hFFFFFF80);
    drive_and_check(16'hFF7F, 2'b11, 1'b1, "sext8_pos");
    check("sext8_pos_const", out_s, 32'h0000007F);
    drive_and_check(16'h0080, 2'b00, 1'b1, "sext_bit7_only");
    drive_and_check(16'h7F00, 2'b11, 1'b1, "sext8_hi_ignored");

    for (int m = 0; m < 4; m++) begin
      drive_and_check(16'h0000, 2'(m), 1'b1, "zero_in");
      check("zero_const", out_s, 32'h0);
    end

    drive_and_check(16'h1234, 2'b00, 1'b1, "hold_cap");
    drive_and_check(16'hABCD, 2'b00, 1'b0, "hold_idle");
    check("hold_const", out_s, 32'h00001234);

    drive_and_check(16'h5555, 2'b10, 1'b1, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_out", out_s, 32'h0);
    check("mid_rst_vld", {31'b0, out_valid_s}, 32'h0);
    exp_out = '0;
    #1;
    rst = 1'b0;
    drive_and_check(16'h0002, 2'b00, 1'b1, "post_rst");
    check("post_rst_const", out_s, 32'h00000002);

    for (int i = 0; i < 300; i++) begin
      drive_and_check(16'($urandom), 2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) != 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
